// File: rtl/meter_ctrl.sv
// Parking-meter time counter: debounced coin/preset inputs, per-channel credits, saturating tick decrement.
// Build option METER_BCD_OUT_EN adds port bcd, a registered BCD copy of count.
module meter_ctrl #(
    parameter int                         NUM_CH      = 4,
    parameter int                         CNT_W       = 14,
    parameter int                         MAX_COUNT   = 9999,
    parameter logic [NUM_CH*CNT_W-1:0]    INC_VALUES  = {14'd550, 14'd200, 14'd180, 14'd10},
    parameter int                         PRESET0     = 10,
    parameter int                         PRESET1     = 205,
    parameter int                         TICK_CYCLES = 100000000,
    parameter int                         DEB_CYCLES  = 1000000,
    parameter int                         LOW_THRESH  = 200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] buttons,
    input  logic [1:0]        preset,
    output logic [CNT_W-1:0]  count,
    output logic [1:0]        state,
    output logic              tick
`ifdef METER_BCD_OUT_EN
    ,
    output logic [15:0]       bcd
`endif
);

    // state      | meaning
    // ST_EXPIRED | count == 0
    // ST_LOW     | 0 < count < LOW_THRESH
    // ST_RUNNING | count >= LOW_THRESH
    typedef enum logic [1:0] {
        ST_EXPIRED = 2'b00,
        ST_LOW     = 2'b01,
        ST_RUNNING = 2'b10
    } state_t;

    localparam int NIN   = NUM_CH + 2;
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int TCK_W = $clog2(TICK_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_RELOAD = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TCK_W-1:0] TICK_LAST  = TCK_W'(TICK_CYCLES - 1);

    logic [NIN-1:0]    raw, sync1, sync2, stable, stable_d, rise;
    logic [DEB_W-1:0]  deb_cnt [NIN];
    logic [NUM_CH-1:0] coin_pulse, pending, eff, svc;
    logic [1:0]        pre_pulse;
    logic              pre_any, found, tick_wrap, dec;
    logic [CNT_W-1:0]  inc, next_count;
    logic [CNT_W:0]    sum;
    logic [TCK_W-1:0]  tick_cnt;
    state_t            state_q, next_state;

    assign raw = {preset, buttons};

    // Each input must differ from its accepted value for DEB_CYCLES consecutive samples to flip it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < NIN; i++) deb_cnt[i] <= DEB_RELOAD;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= DEB_RELOAD;
                end else if (deb_cnt[i] == '0) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= DEB_RELOAD;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign rise       = stable & ~stable_d;
    assign coin_pulse = rise[NUM_CH-1:0];
    assign pre_pulse  = rise[NIN-1:NUM_CH];
    assign pre_any    = |pre_pulse;
    assign tick_wrap  = (tick_cnt == TICK_LAST);
    assign tick       = tick_wrap & ~pre_any;

    // Fresh pulses join the pending set so a coin can be credited in the same cycle it arrives.
    always_comb begin
        eff   = pending | coin_pulse;
        svc   = '0;
        inc   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (eff[i] && !found) begin
                found  = 1'b1;
                svc[i] = 1'b1;
                inc    = INC_VALUES[i*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        dec = tick && (count != '0);
        sum = {1'b0, count} + {1'b0, inc} - (CNT_W+1)'(dec);
        if (pre_any)
            next_count = pre_pulse[1] ? CNT_W'(PRESET1) : CNT_W'(PRESET0);
        else if (sum > (CNT_W+1)'(MAX_COUNT))
            next_count = CNT_W'(MAX_COUNT);
        else
            next_count = sum[CNT_W-1:0];

        if (next_count == '0)
            next_state = ST_EXPIRED;
        else if (next_count < CNT_W'(LOW_THRESH))
            next_state = ST_LOW;
        else
            next_state = ST_RUNNING;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            state_q  <= ST_EXPIRED;
            pending  <= '0;
            tick_cnt <= '0;
        end else begin
            count    <= next_count;
            state_q  <= next_state;
            pending  <= pre_any ? '0 : (eff & ~svc);
            tick_cnt <= (pre_any || tick_wrap) ? '0 : tick_cnt + 1'b1;
        end
    end

    assign state = state_q;

`ifdef METER_BCD_OUT_EN
    function automatic logic [15:0] to_bcd(input logic [CNT_W-1:0] bin);
        logic [15:0] d;
        d = '0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            for (int k = 0; k < 4; k++)
                if (d[k*4 +: 4] >= 4'd5) d[k*4 +: 4] = d[k*4 +: 4] + 4'd3;
            d = {d[14:0], bin[i]};
        end
        return d;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bcd <= '0;
        else          bcd <= to_bcd(count);
    end
`endif

endmodule

// File: tb/tb_meter_ctrl.sv
// Scoreboard bench for meter_ctrl: each press queues its expected credit/preset edge, a
// per-cycle monitor applies them to a time-budget model and compares count, state, tick (and bcd).
module tb_meter_ctrl;

    localparam int TICK = 20;
    localparam int DEB  = 4;
    localparam int MAXC = 9999;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  buttons = '0;
    logic [1:0]  preset = '0;
    logic [13:0] count;
    logic [1:0]  state;
    logic        tick;
`ifdef METER_BCD_OUT_EN
    logic [15:0] bcd;
`endif

    meter_ctrl #(
        .NUM_CH(4), .CNT_W(14), .MAX_COUNT(MAXC),
        .PRESET0(10), .PRESET1(205),
        .TICK_CYCLES(TICK), .DEB_CYCLES(DEB), .LOW_THRESH(200)
    ) dut (
        .clk(clk), .reset_n(reset_n), .buttons(buttons), .preset(preset),
        .count(count), .state(state), .tick(tick)
`ifdef METER_BCD_OUT_EN
        , .bcd(bcd)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_no;
        int kind;     // 0 coin credit, 1 preset load
        int val;
    } ev_t;

    ev_t sb_q[$];
    int  total = 0, bad = 0;
    int  cyc = 0, tphase = 0, m_count = 0, m_prev = 0;
    int  inc_tab[4] = '{10, 180, 200, 550};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got=%0d expected=%0d", tag, cyc, act, exp);
        end
    endtask

    function automatic int exp_state(input int c);
        if (c == 0)   return 0;
        if (c < 200)  return 1;
        return 2;
    endfunction

    function automatic logic [15:0] dec_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(negedge clk) begin
        ev_t ev;
        int  inc, dec, pval;
        bit  pre, t_exp;
        if (!reset_n) begin
            cyc = 0; tphase = 0; m_count = 0; m_prev = 0;
            sb_q.delete();
            check("rst_count", count, 0);
            check("rst_state", state, 0);
            check("rst_tick", tick, 0);
`ifdef METER_BCD_OUT_EN
            check("rst_bcd", bcd, 0);
`endif
        end else begin
            cyc++;
            m_prev = m_count;
            inc = 0; pre = 0; pval = 0;
            while (sb_q.size() > 0 && sb_q[0].edge_no <= cyc) begin
                ev = sb_q.pop_front();
                if (ev.edge_no < cyc) check("sb_late", ev.edge_no, cyc);
                else if (ev.kind == 1) begin pre = 1; pval = ev.val; end
                else inc += ev.val;
            end
            if (pre) begin
                m_count = pval;
                tphase  = cyc;
            end else begin
                dec = (((cyc - tphase) % TICK) == 0 && m_count > 0) ? 1 : 0;
                m_count = m_count + inc - dec;
                if (m_count > MAXC) m_count = MAXC;
            end
            t_exp = (((cyc + 1 - tphase) % TICK) == 0) &&
                    !(sb_q.size() > 0 && sb_q[0].edge_no == cyc + 1 && sb_q[0].kind == 1);
            check("count", count, m_count);
            check("state", state, exp_state(m_count));
            check("tick", tick, t_exp);
`ifdef METER_BCD_OUT_EN
            check("bcd", bcd, dec_bcd(m_prev));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Raw edge is sampled at the next posedge; debounced pulse credits 7 edges later.
    task automatic press(input logic [3:0] btn, input logic [1:0] pre, input int hold);
        int k;
        k = 0;
        if (pre != 2'b00) begin
            sb_q.push_back('{cyc + 2 + DEB + 1, 1, pre[1] ? 205 : 10});
        end else begin
            for (int i = 0; i < 4; i++)
                if (btn[i]) begin
                    sb_q.push_back('{cyc + 2 + DEB + 1 + k, 0, inc_tab[i]});
                    k++;
                end
        end
        buttons = btn;
        preset  = pre;
        step(hold);
        buttons = '0;
        preset  = '0;
        step(10);
    endtask

    initial begin
        step(3);
        #1 reset_n = 1'b1;
        step(1);

        press(4'b0001, 2'b00, 8);
        step(200);
        check("expired_count", count, 0);
        check("expired_state", state, 0);

        press(4'b1010, 2'b00, 8);
        press(4'b0111, 2'b11, 8);
        step(25);
        press(4'b0000, 2'b01, 8);

        for (int k = 0; k < TICK; k++) begin
            if (((cyc + 7 - tphase) % TICK) == 0) break;
            step(1);
        end
        press(4'b0100, 2'b00, 8);

        for (int k = 0; k < 15 && m_count < 9500; k++) press(4'b1111, 2'b00, 8);
        press(4'b1000, 2'b00, 8);
        check("sat_state", state, 2);

        buttons[0] = 1'b1;
        step(3);
        buttons[0] = 1'b0;
        step(12);

        press(4'b1000, 2'b00, 8);
        buttons[3] = 1'b1;
        step(3);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_state", state, 0);
        buttons = '0;
        step(3);
        #1 reset_n = 1'b1;
        step(40);
        check("post_rst_count", count, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/meter_ctrl.md
Name: meter_ctrl

Overview:
Parametrised parking-meter time counter with NUM_CH debounced coin/button channels, two load presets and a once-per-TICK_CYCLES decrement. Successor to the fixed 4-button meter. Adds per-channel increments and pending-coin capture so simultaneous presses are never lost. Adds merged coin+tick arithmetic, saturation and a status FSM. Sits between the board buttons and the seven-segment display driver.

Parameters:
NUM_CH, 4, number of coin/button channels (1..8)
CNT_W, 14, width of count (must hold MAX_COUNT)
MAX_COUNT, 9999, saturation ceiling of count
INC_VALUES, {14'd550,14'd200,14'd180,14'd10}, packed NUM_CH*CNT_W increments; channel i uses bits [i*CNT_W +: CNT_W]
PRESET0, 10, value loaded by preset[0]
PRESET1, 205, value loaded by preset[1]
TICK_CYCLES, 100000000, clk cycles per decrement tick
DEB_CYCLES, 1000000, cycles a raw input must stay stable to be accepted
LOW_THRESH, 200, count below this (and nonzero) is LOW

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
buttons  input  NUM_CH  raw asynchronous channel inputs, active-high
preset  input  2  raw preset inputs; [0] loads PRESET0, [1] loads PRESET1
count  output  CNT_W  remaining time, registered
state  output  2  00 EXPIRED, 01 LOW, 10 RUNNING, registered
tick  output  1  one-cycle pulse on each decrement-period boundary
bcd  output  16  4 BCD digits of count (only with METER_BCD_OUT_EN)

Behaviour:
- Reset (reset_n=0, async): count=0, state=EXPIRED, tick=0, pending=0, tick counter=0, debouncers cleared (stable value 0), bcd=0.
- Inputs (buttons and preset): 2-FF synchroniser, then a stable-counter debouncer. Output toggles only after DEB_CYCLES consecutive equal samples. A rising edge of the debounced value gives a 1-cycle pulse. Latency from raw edge: 2+DEB_CYCLES+1 cycles.
- Coin pulses set pending[i]. Each cycle the lowest-index set pending bit is serviced and cleared. A pulse on a channel already pending is merged (one credit). Pulses on different channels are all eventually credited.
- Tick counter counts 0..TICK_CYCLES-1 and wraps. tick=1 in the wrap cycle.
- Per-cycle update, priority order:
  1) preset pulse: count<=PRESET1 if preset[1], else PRESET0 (preset[1] wins). Clear pending. Reset the tick counter to 0. tick is suppressed that cycle.
  2) otherwise next = count + inc(serviced channel or 0) - (tick && count>0 ? 1 : 0), computed at CNT_W+1 bits. A tick coinciding with a coin is applied in the same cycle, never dropped.
  3) saturate: next>MAX_COUNT gives count<=MAX_COUNT. Count never wraps below 0.
- State FSM, registered from the new count: count==0 gives EXPIRED; 0<count<LOW_THRESH gives LOW; otherwise RUNNING. Any state may go to any other in one cycle (e.g. EXPIRED to RUNNING on a 550 coin). state lags count by 0 cycles (updated in the same edge).
- reset_n low mid-debounce or with coins pending discards everything, with no credit after release.

Optional Feature:
METER_BCD_OUT_EN
- Defined: bcd port exists. It is the registered binary-to-BCD conversion of count, 1-cycle latency. Values above 9999 are impossible because MAX_COUNT<=9999 is required.
- Undefined: no bcd port and no conversion logic; the display driver converts.

Test Plan:
(DEB_CYCLES=4, TICK_CYCLES=20 for all)
- Release reset, press buttons[0] ≥8 cycles -> count 0->10 once; state EXPIRED->LOW; 10 ticks later count=0, state=EXPIRED, no further decrement.
- Press buttons[1] and buttons[3] in the same cycle from count=0 -> count 180 one cycle after the pulses, then 730 the next cycle (both credited, channel 1 first).
- count=9900, press buttons[3] -> count=9999 (saturated), state RUNNING.
- Align a buttons[2] pulse with tick at count=50 -> count=249 in that single cycle.
- preset=2'b11 while coins pending at count=300 -> count=205, pending cleared, the next tick arrives exactly 20 cycles later.
- Glitch buttons[0] high for 3 cycles -> no change; assert reset_n low mid-press at count=500 -> count=0 immediately (async), no credit after release. With METER_BCD_OUT_EN: count=1234 -> bcd=16'h1234 one cycle later.
